// File: rtl/axil_drm_pkg.sv
// Shared constants, FSM encodings and reset helper for the DRM mailbox.
// Holds the register offsets, AXI response codes and the mailbox reset pattern.
package axil_drm_pkg;

  localparam int unsigned OFF_STATUS    = 32'h00;
  localparam int unsigned OFF_EVT_CNT   = 32'h04;
  localparam int unsigned OFF_MBOX_BASE = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  // Mailbox i resets to one byte pattern repeated across all lanes.
  function automatic logic [31:0] mbox_rst(input int unsigned i);
    logic [7:0] b;
    b = 8'(32'hAB + 32'h11 * i);
    return {4{b}};
  endfunction

endpackage

// File: rtl/axil_drm_mailbox_if.sv
// AXI4-Lite bus bundle for the DRM mailbox (AW/W/B and AR/R channels).
// slave: register block side; master: host shell side.
interface axil_drm_mailbox_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_drm_mailbox_act.sv
// Two-stage activation compare: XOR against the expected code, then reduce.
// Ports: clk, areset, activation_code (128b in), activated (registered out).
module drm_activation_check #(
  parameter logic [127:0] EXP_ACT_CODE =
    128'h7E745E528F0CF2F36C304A2F18DB0CE0
) (
  input  logic         clk,
  input  logic         areset,
  input  logic [127:0] activation_code,
  output logic         activated
);
  logic [127:0] r_x;
  logic         r_nz;

  // r_nz keeps an all-zero code from ever activating, whatever EXP is.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_x       <= '0;
      r_nz      <= 1'b0;
      activated <= 1'b0;
    end else begin
      r_x       <= activation_code ^ EXP_ACT_CODE;
      r_nz      <= |activation_code;
      activated <= ~|r_x & r_nz;
    end
  end
endmodule

// File: rtl/axil_drm_mailbox.sv
// AXI4-Lite register block: STATUS, EVT_CNT and N_MBOX DRM-gated mailboxes.
// Ports: clk, areset, s_axi (slave bus), activation_code, activated, metering_event.
module axil_drm_mailbox
  import axil_drm_pkg::*;
#(
  parameter int unsigned  N_MBOX        = 3,
  parameter int unsigned  ADDR_W        = 16,
  parameter logic [127:0] EXP_ACT_CODE  =
    128'h7E745E528F0CF2F36C304A2F18DB0CE0,
  parameter bit           LOCK_INACTIVE = 1'b1,
  parameter logic [15:0]  DIAG_TAG      = 16'h06AE
) (
  input  logic                clk,
  input  logic                areset,
  axil_drm_mailbox_if.slave   s_axi,
  input  logic [127:0]        activation_code,
  output logic                activated,
  output logic                metering_event
);
  localparam int unsigned WW = ADDR_W - 2;
  localparam logic [WW-1:0] W_STATUS = WW'(OFF_STATUS >> 2);
  localparam logic [WW-1:0] W_EVT    = WW'(OFF_EVT_CNT >> 2);

  function automatic logic [WW-1:0] mb_word(input int unsigned i);
    return WW'((OFF_MBOX_BASE >> 2) + i);
  endfunction

  logic              r_live;
  wr_state_e         r_wst, w_wst_nxt;
  rd_state_e         r_rst, w_rst_nxt;
  logic              r_aw_hold, r_w_hold;
  logic [WW-1:0]     r_aw_word;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic [31:0]       r_evt;
  logic [31:0]       r_mbox [N_MBOX];

  logic              w_awready, w_wready, w_bvalid;
  logic              w_arready, w_rvalid;
  logic              w_commit, w_ar_hs;
  logic              w_mb_lock;
  logic [1:0]        w_wr_resp, w_rd_resp;
  logic              w_wr_evt;
  logic [N_MBOX-1:0] w_wr_mb;
  logic [31:0]       w_rd_data;
  logic [WW-1:0]     w_ar_word;

  drm_activation_check #(
    .EXP_ACT_CODE(EXP_ACT_CODE)
  ) u_act (
    .clk            (clk),
    .areset         (areset),
    .activation_code(activation_code),
    .activated      (activated)
  );

  assign w_ar_word      = s_axi.araddr[ADDR_W-1:2];
  assign w_ar_hs        = s_axi.arvalid & w_arready;
  assign w_mb_lock      = LOCK_INACTIVE & ~activated;
  assign metering_event = w_ar_hs;

  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = w_arready;
  assign s_axi.rvalid  = w_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  // Holds readies low until the first edge after reset release.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  always_comb begin
    w_wst_nxt = r_wst;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    w_commit  = 1'b0;
    unique case (r_wst)
      WR_IDLE: begin
        w_awready = r_live & ~r_aw_hold;
        w_wready  = r_live & ~r_w_hold;
        w_commit  = r_aw_hold & r_w_hold;
        if (w_commit) w_wst_nxt = WR_RESP;
      end
      WR_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi.bready) w_wst_nxt = WR_IDLE;
      end
    endcase
  end

  always_comb begin
    w_rst_nxt = r_rst;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    unique case (r_rst)
      RD_IDLE: begin
        w_arready = r_live;
        if (s_axi.arvalid & r_live) w_rst_nxt = RD_DATA;
      end
      RD_DATA: begin
        w_rvalid = 1'b1;
        if (s_axi.rready) w_rst_nxt = RD_IDLE;
      end
    endcase
  end

  always_comb begin
    w_wr_resp = RESP_SLVERR;
    w_wr_evt  = 1'b0;
    w_wr_mb   = '0;
    if (r_aw_word == W_EVT) begin
      w_wr_evt  = 1'b1;
      w_wr_resp = RESP_OKAY;
    end
    for (int unsigned i = 0; i < N_MBOX; i++) begin
      if (r_aw_word == mb_word(i) && !w_mb_lock) begin
        w_wr_mb[i] = 1'b1;
        w_wr_resp  = RESP_OKAY;
      end
    end
  end

  always_comb begin
    w_rd_data = {DIAG_TAG, 16'(s_axi.araddr)};
    w_rd_resp = RESP_SLVERR;
    if (w_ar_word == W_STATUS) begin
      w_rd_data = {31'b0, activated};
      w_rd_resp = RESP_OKAY;
    end
    if (w_ar_word == W_EVT) begin
      w_rd_data = r_evt;
      w_rd_resp = RESP_OKAY;
    end
    for (int unsigned i = 0; i < N_MBOX; i++) begin
      if (w_ar_word == mb_word(i)) begin
        w_rd_data = r_mbox[i];
        w_rd_resp = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wst     <= WR_IDLE;
      r_aw_hold <= 1'b0;
      r_w_hold  <= 1'b0;
      r_aw_word <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wst <= w_wst_nxt;
      if (s_axi.awvalid & w_awready) begin
        r_aw_hold <= 1'b1;
        r_aw_word <= s_axi.awaddr[ADDR_W-1:2];
      end
      if (s_axi.wvalid & w_wready) begin
        r_w_hold <= 1'b1;
        r_wdata  <= s_axi.wdata;
        r_wstrb  <= s_axi.wstrb;
      end
      if (w_commit) begin
        r_aw_hold <= 1'b0;
        r_w_hold  <= 1'b0;
        r_bresp   <= w_wr_resp;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < N_MBOX; i++)
        r_mbox[i] <= mbox_rst(i);
    end else begin
      for (int unsigned i = 0; i < N_MBOX; i++)
        for (int unsigned b = 0; b < 4; b++)
          if (w_commit && w_wr_mb[i] && r_wstrb[b])
            r_mbox[i][8*b +: 8] <= r_wdata[8*b +: 8];
    end
  end

  // A clearing write landing on a read handshake wins over the increment.
  always_ff @(posedge clk or posedge areset) begin
    if (areset)                   r_evt <= '0;
    else if (w_commit & w_wr_evt) r_evt <= '0;
    else if (w_ar_hs)             r_evt <= r_evt + 32'd1;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_rst   <= RD_IDLE;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else begin
      r_rst <= w_rst_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_axil_drm_mailbox.sv
// Self-checking bench for axil_drm_mailbox: vector table plus corner sequences.
// R/B beats are checked against scoreboard queues filled at stimulus time.
module tb_axil_drm_mailbox;

  localparam logic [127:0] EXP =
    128'h7E745E528F0CF2F36C304A2F18DB0CE0;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] ed;
    logic [1:0]  er;
  } vec_t;

  logic         clk;
  logic         areset;
  logic [127:0] activation_code;
  logic         activated;
  logic         metering_event;

  int n_cmp = 0;
  int n_bad = 0;
  int n_met = 0;
  int n_rd  = 0;

  rexp_t      rq[$];
  logic [1:0] bq[$];
  vec_t       tbl[10];

  axil_drm_mailbox_if #(.ADDR_W(16)) bus ();

  axil_drm_mailbox #(
    .N_MBOX       (3),
    .ADDR_W       (16),
    .EXP_ACT_CODE (EXP),
    .LOCK_INACTIVE(1'b1),
    .DIAG_TAG     (16'h06AE)
  ) dut (
    .clk            (clk),
    .areset         (areset),
    .s_axi          (bus),
    .activation_code(activation_code),
    .activated      (activated),
    .metering_event (metering_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rexp_t e;
    if (metering_event) n_met++;
    if (!areset && bus.rvalid && bus.rready) begin
      if (rq.size() == 0) chk("r_unexp", 1, 0);
      else begin
        e = rq.pop_front();
        chk("rdata", bus.rdata, e.data);
        chk("rresp", {30'b0, bus.rresp}, {30'b0, e.resp});
      end
    end
    if (!areset && bus.bvalid && bus.bready) begin
      if (bq.size() == 0) chk("b_unexp", 1, 0);
      else chk("bresp", {30'b0, bus.bresp}, {30'b0, bq.pop_front()});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int w, input string nm);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (w == 0)      ok = bus.arready;
      else if (w == 1) ok = bus.rvalid;
      else if (w == 2) ok = bus.awready & bus.wready;
      else             ok = bus.bvalid;
      if (ok) break;
    end
    if (!ok) chk(nm, 0, 1);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] ed,
                    input logic [1:0] er);
    rq.push_back('{ed, er});
    n_rd++;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    wait_hs(0, "ar_timeout");
    cyc(1);
    bus.arvalid = 1'b0;
    wait_hs(1, "r_timeout");
    cyc(1);
    bus.rready = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] er);
    bq.push_back(er);
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    wait_hs(2, "aw_timeout");
    cyc(1);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    wait_hs(3, "b_timeout");
    cyc(1);
    bus.bready = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    if (v.wr) wr(v.addr, v.wd, v.st, v.er);
    else      rd(v.addr, v.ed, v.er);
  endtask

  // Write commits on the same edge as the AR handshake.
  task automatic overlap(input logic [15:0] wa, input logic [31:0] wd,
                         input logic [15:0] ra, input logic [31:0] ed);
    bq.push_back(OK);
    bus.awaddr  = wa;
    bus.wdata   = wd;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    cyc(1);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    rq.push_back('{ed, OK});
    n_rd++;
    bus.araddr  = ra;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    cyc(1);
    bus.arvalid = 1'b0;
    cyc(3);
    bus.bready = 1'b0;
    bus.rready = 1'b0;
  endtask

  initial begin
    int cnt;
    tbl[0] = '{1'b0, 16'h0000, 32'h0, 4'h0, 32'h0000_0000, OK};
    tbl[1] = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'hABAB_ABAB, OK};
    tbl[2] = '{1'b0, 16'h0014, 32'h0, 4'h0, 32'hBCBC_BCBC, OK};
    tbl[3] = '{1'b0, 16'h0018, 32'h0, 4'h0, 32'hCDCD_CDCD, OK};
    tbl[4] = '{1'b1, 16'h0010, 32'hFFFF_FFFF, 4'hF, 32'h0, ERR};
    tbl[5] = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'hABAB_ABAB, OK};
    tbl[6] = '{1'b1, 16'h0000, 32'h1, 4'hF, 32'h0, ERR};
    tbl[7] = '{1'b0, 16'h001C, 32'h0, 4'h0, 32'h06AE_001C, ERR};
    tbl[8] = '{1'b1, 16'h0040, 32'h5, 4'hF, 32'h0, ERR};
    tbl[9] = '{1'b0, 16'h0003, 32'h0, 4'h0, 32'h0000_0000, OK};

    areset          = 1'b1;
    activation_code = '0;
    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0;
    bus.rready  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ctl", {25'b0, bus.awready, bus.wready, bus.arready,
        bus.bvalid, bus.rvalid, activated, metering_event}, 0);
    chk("rst_dat", {bus.rdata[29:0], bus.rresp}, 0);
    chk("rst_bresp", {30'b0, bus.bresp}, 0);
    cyc(1);
    areset = 1'b0;
    @(negedge clk);
    chk("rdy_lag", {29'b0, bus.awready, bus.wready, bus.arready}, 0);
    @(negedge clk);
    chk("rdy_up", {29'b0, bus.awready, bus.wready, bus.arready}, 7);
    cyc(1);

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
      if (i == 3) chk("met4", n_met, 4);
    end

    activation_code = EXP;
    @(negedge clk); chk("act_0clk", {31'b0, activated}, 0);
    @(negedge clk); chk("act_1clk", {31'b0, activated}, 0);
    @(negedge clk); chk("act_2clk", {31'b0, activated}, 1);
    cyc(1);
    wr(16'h0014, 32'h1234_5678, 4'b0011, OK);
    rd(16'h0014, 32'hBCBC_5678, OK);
    wr(16'h0018, 32'hDEAD_BEEF, 4'b1100, OK);
    rd(16'h0018, 32'hDEAD_CDCD, OK);
    rd(16'h0000, 32'h1, OK);

    activation_code = '0;
    repeat (3) @(negedge clk);
    chk("deact", {31'b0, activated}, 0);
    cyc(1);
    wr(16'h0010, 32'hFFFF_FFFF, 4'hF, ERR);
    rd(16'h0010, 32'hABAB_ABAB, OK);

    activation_code = EXP;
    cyc(3);
    bq.push_back(OK);
    bus.wdata  = 32'h1122_3344;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    @(negedge clk);
    chk("w_rdy", {31'b0, bus.wready}, 1);
    @(negedge clk);
    chk("w_drop", {30'b0, bus.wready, bus.awready}, 1);
    cyc(2);
    bus.awaddr  = 16'h0018;
    bus.awvalid = 1'b1;
    wait_hs(3, "b_timeout");
    cnt = 1;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(bus.bvalid);
    end
    chk("b_hold", cnt, 5);
    cyc(1);
    bus.bready = 1'b1;
    cyc(1);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(bus.bvalid);
    end
    chk("no_2nd_b", cnt, 0);
    cyc(1);
    rd(16'h0018, 32'h1122_3344, OK);

    rq.push_back('{32'h06AE_0200, ERR});
    n_rd++;
    bus.araddr  = 16'h0200;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    wait_hs(0, "ar_timeout");
    cyc(1);
    bus.arvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rhold_ctl", {30'b0, bus.rvalid, bus.arready}, 2);
      chk("rhold_dat", bus.rdata, 32'h06AE_0200);
    end
    cyc(1);
    bus.rready = 1'b1;
    cyc(1);
    bus.rready = 1'b0;
    @(negedge clk);
    chk("ar_back", {31'b0, bus.arready}, 1);
    cyc(1);

    wr(16'h0004, 32'h0, 4'hF, OK);
    repeat (3) rd(16'h0000, 32'h1, OK);
    rd(16'h0004, 32'd3, OK);
    rd(16'h0004, 32'd4, OK);
    wr(16'h0004, 32'h9, 4'hF, OK);
    rd(16'h0004, 32'd0, OK);
    overlap(16'h0004, 32'h0, 16'h0000, 32'h1);
    rd(16'h0004, 32'd0, OK);
    force dut.r_evt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_evt;
    cyc(1);
    rd(16'h0004, 32'hFFFF_FFFF, OK);
    rd(16'h0004, 32'd0, OK);

    overlap(16'h0018, 32'hCAFE_F00D, 16'h0018, 32'h1122_3344);
    rd(16'h0018, 32'hCAFE_F00D, OK);

    bus.awaddr  = 16'h0018;
    bus.wdata   = 32'h5555_AAAA;
    bus.wstrb   = 4'hF;
    bus.araddr  = 16'h0010;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.arvalid = 1'b1;
    bus.bready  = 1'b0;
    bus.rready  = 1'b0;
    n_rd++;
    cyc(1);
    areset      = 1'b1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    @(negedge clk);
    chk("abort_rdy", {29'b0, bus.awready, bus.wready, bus.arready}, 0);
    cyc(1);
    areset     = 1'b0;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(bus.bvalid | bus.rvalid);
    end
    chk("abort_beat", cnt, 0);
    cyc(1);
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    rd(16'h0018, 32'hCDCD_CDCD, OK);

    cyc(2);
    chk("rq_empty", rq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    chk("met_total", n_met, n_rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
